// File: rtl/accel_pkg.sv
// Shared accelerator definitions: opcodes, regions, instruction layout, load states.
// Latency: n/a (types, constants and a combinational legality helper).
// Backpressure: n/a.
package accel_pkg;

  localparam logic [7:0] OP_PRELOAD_A = 8'h12;
  localparam logic [7:0] OP_PRELOAD_B = 8'h22;
  localparam logic [7:0] OP_MOVE      = 8'h11;
  localparam logic [7:0] OP_COMP      = 8'h14;
  localparam logic [7:0] OP_HALT      = 8'hFF;

  localparam logic [3:0] REG_SHM   = 4'b0001;
  localparam logic [3:0] REG_INBUF = 4'b0010;
  localparam logic [3:0] REG_WBUF  = 4'b0100;

  // Word substituted for fetches beyond the loaded program.
  localparam logic [31:0] HALT_WORD = 32'h0FF0_0000;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [3:0] func;
    logic [3:0] opcode;
    logic [9:0] rs1;
    logic [9:0] rs2;
  } instr_t;

  typedef enum logic [1:0] {
    LS_EMPTY,
    LS_LOADING,
    LS_READY
  } load_state_t;

  // Where the instruction register currently takes its word from.
  typedef enum logic [1:0] {
    IR_ZERO,
    IR_MEM,
    IR_HALT
  } ir_src_t;

  // Reserved bits clear, listed op, and region fields consistent with the op.
  function automatic logic is_legal(input instr_t i);
    logic       ok;
    logic [3:0] reg1;
    logic [3:0] reg2;
    reg1 = i.rs1[9:6];
    reg2 = i.rs2[9:6];
    ok   = 1'b0;
    if (i.rsvd == 4'h0) begin
      case ({i.func, i.opcode})
        OP_PRELOAD_A, OP_PRELOAD_B: ok = (reg1 == REG_SHM) && (reg2 == REG_SHM);
        OP_MOVE:  ok = (reg1 == REG_SHM) && ((reg2 == REG_INBUF) || (reg2 == REG_WBUF));
        OP_COMP:  ok = 1'b1;
        OP_HALT:  ok = 1'b1;
        default:  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Program store: DEPTH x INSTR_W, synchronous write and synchronous read, no reset.
// Latency: read data registered one cycle after rd_en; holds while rd_en is low.
// Backpressure: none; caller guarantees at most one write and one read per cycle.
module instr_mem #(
  parameter int DEPTH   = 256,
  parameter int INSTR_W = 32,
  parameter int AW      = 8
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write port and registered read port; contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Program load port, instruction fetch register and decode stage feeding the controller.
// Latency: fetch 1 cycle (ren -> ir), decode 1 cycle (decoder_en -> func/opcode/rs1/rs2).
// Backpressure: load_ready high only in LOADING below DEPTH words; fetch/decode never stall.
module instr_fetch_decode
  import accel_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_done,
  output logic [8:0]         load_count,
  input  logic [7:0]         pc,
  input  logic               insbuf_ren,
  input  logic               decoder_en,
  output logic [3:0]         func,
  output logic [3:0]         opcode,
  output logic [9:0]         rs1,
  output logic [9:0]         rs2,
  output logic               illegal,
  output logic [7:0]         illegal_pc
);

  localparam logic [8:0] DEPTH_C = 9'(DEPTH);

  load_state_t        state;
  ir_src_t            ir_src;
  logic [7:0]         ir_pc;
  logic [INSTR_W-1:0] rd_data;
  instr_t             ir;
  logic               ir_legal;
  logic               accept;
  logic               fetch;
  logic               in_range;

  // load_start wins over a same-cycle handshake or fetch.
  assign accept   = (state == LS_LOADING) && load_ready && load_valid && !load_start;
  assign fetch    = (state == LS_READY) && insbuf_ren && !load_start;
  assign in_range = {1'b0, pc} < load_count;

  instr_mem #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .AW      (8)
  ) u_mem (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (load_count[7:0]),
    .wr_data (load_data),
    .rd_en   (fetch && in_range),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  // The instruction register is the memory read register, HALT, or cleared zero.
  always_comb begin
    ir = instr_t'(32'h0);
    case (ir_src)
      IR_MEM:  ir = instr_t'(rd_data);
      IR_HALT: ir = instr_t'(HALT_WORD);
      default: ir = instr_t'(32'h0);
    endcase
    ir_legal = is_legal(ir);
  end

  // Load FSM: count accepted words, finish on last word or a full store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LS_EMPTY;
      load_count <= 9'd0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
    end else if (load_start) begin
      state      <= LS_LOADING;
      load_count <= 9'd0;
      load_ready <= (DEPTH_C != 9'd0);
      load_done  <= 1'b0;
    end else if (accept) begin
      load_count <= load_count + 9'd1;
      if (load_last || (load_count + 9'd1 == DEPTH_C)) begin
        state      <= LS_READY;
        load_ready <= 1'b0;
        load_done  <= 1'b1;
      end
    end
  end

  // Fetch: select ir source and remember the pc the word came from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_src <= IR_ZERO;
      ir_pc  <= 8'd0;
    end else if (load_start) begin
      ir_src <= IR_ZERO;
      ir_pc  <= 8'd0;
    end else if (fetch) begin
      ir_src <= in_range ? IR_MEM : IR_HALT;
      ir_pc  <= pc;
    end
  end

  // Decode: register fields, forcing HALT on illegal encodings.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      func   <= 4'h0;
      opcode <= 4'h0;
      rs1    <= 10'h0;
      rs2    <= 10'h0;
    end else if (decoder_en) begin
      if (ir_legal) begin
        func   <= ir.func;
        opcode <= ir.opcode;
        rs1    <= ir.rs1;
        rs2    <= ir.rs2;
      end else begin
        func   <= 4'hF;
        opcode <= 4'hF;
        rs1    <= 10'h0;
        rs2    <= 10'h0;
      end
    end
  end

  // Sticky illegal flag holding the pc of the first offending fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal    <= 1'b0;
      illegal_pc <= 8'd0;
    end else if (load_start) begin
      illegal    <= 1'b0;
      illegal_pc <= 8'd0;
    end else if (decoder_en && !ir_legal && !illegal) begin
      illegal    <= 1'b1;
      illegal_pc <= ir_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: load, fetch/decode, HALT substitution, illegal tracking.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: load words are held until load_ready handshakes.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = 32'h0;
  logic        load_last = 1'b0;
  logic        load_done;
  logic [8:0]  load_count;
  logic [7:0]  pc = 8'h0;
  logic        insbuf_ren = 1'b0;
  logic        decoder_en = 1'b0;
  logic [3:0]  func;
  logic [3:0]  opcode;
  logic [9:0]  rs1;
  logic [9:0]  rs2;
  logic        illegal;
  logic [7:0]  illegal_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch_decode #(.DEPTH(256), .INSTR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_done  (load_done),
    .load_count (load_count),
    .pc         (pc),
    .insbuf_ren (insbuf_ren),
    .decoder_en (decoder_en),
    .func       (func),
    .opcode     (opcode),
    .rs1        (rs1),
    .rs2        (rs2),
    .illegal    (illegal),
    .illegal_pc (illegal_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Controller sequence: ren at t, decoder_en at t+1, outputs checked at t+2.
  task automatic fetch_decode(input logic [7:0] a);
    pc         = a;
    insbuf_ren = 1'b1;
    tick();
    insbuf_ren = 1'b0;
    decoder_en = 1'b1;
    tick();
    decoder_en = 1'b0;
  endtask

  task automatic chk_dec(input string tag, input logic [3:0] f, input logic [3:0] o,
                         input logic [9:0] r1, input logic [9:0] r2);
    chk({tag, ".func"},   32'(func),   32'(f));
    chk({tag, ".opcode"}, 32'(opcode), 32'(o));
    chk({tag, ".rs1"},    32'(rs1),    32'(r1));
    chk({tag, ".rs2"},    32'(rs2),    32'(r2));
  endtask

  initial begin
    // Reset values while reset is held low.
    #3;
    chk("rst.load_count", 32'(load_count), 32'd0);
    chk("rst.load_ready", 32'(load_ready), 32'd0);
    chk("rst.load_done",  32'(load_done),  32'd0);
    chk("rst.illegal",    32'(illegal),    32'd0);
    chk("rst.illegal_pc", 32'(illegal_pc), 32'd0);
    chk_dec("rst", 4'h0, 4'h0, 10'h0, 10'h0);
    #9 reset = 1'b1;

    // Load a 3-word program.
    start_load();
    chk("ld.ready_after_start", 32'(load_ready), 32'd1);
    chk("ld.count_after_start", 32'(load_count), 32'd0);
    push_word(32'h0121_0040, 1'b0);
    push_word(32'h0111_0088, 1'b0);
    push_word(32'h0FF0_0000, 1'b1);
    chk("ld3.count", 32'(load_count), 32'd3);
    chk("ld3.done",  32'(load_done),  32'd1);
    chk("ld3.ready", 32'(load_ready), 32'd0);

    // Move at pc=1: rs1 = bits[19:10] = 0x040 (SHM), rs2 = bits[9:0] = 0x088 (INBUF).
    fetch_decode(8'd1);
    chk_dec("move_pc1", 4'h1, 4'h1, 10'h040, 10'h088);
    chk("move_pc1.illegal", 32'(illegal), 32'd0);
    tick();
    chk_dec("move_hold", 4'h1, 4'h1, 10'h040, 10'h088);

    // Preload at pc=0, then fetch pc=2 while decoding: decode sees the old ir.
    pc = 8'd0; insbuf_ren = 1'b1;
    tick();
    pc = 8'd2; decoder_en = 1'b1;
    tick();
    insbuf_ren = 1'b0;
    chk_dec("preload_pc0", 4'h1, 4'h2, 10'h040, 10'h040);
    tick();
    decoder_en = 1'b0;
    chk_dec("halt_pc2", 4'hF, 4'hF, 10'h0, 10'h0);

    // Out-of-range fetch is substituted with HALT, not flagged illegal.
    fetch_decode(8'd1);
    fetch_decode(8'd5);
    chk_dec("oor_pc5", 4'hF, 4'hF, 10'h0, 10'h0);
    chk("oor_pc5.illegal", 32'(illegal), 32'd0);

    // Unlisted op 0x13 at pc 0.
    start_load();
    push_word(32'h0137_0000, 1'b1);
    chk("ill.count", 32'(load_count), 32'd1);
    fetch_decode(8'd0);
    chk_dec("ill_pc0", 4'hF, 4'hF, 10'h0, 10'h0);
    chk("ill_pc0.illegal",    32'(illegal),    32'd1);
    chk("ill_pc0.illegal_pc", 32'(illegal_pc), 32'd0);
    start_load();
    chk("ill.cleared", 32'(illegal), 32'd0);

    // First-illegal pc is sticky: reserved-bit violation at pc 1, then op 0x13 at pc 0.
    push_word(32'h0137_0000, 1'b0);
    push_word(32'h1121_0040, 1'b1);
    fetch_decode(8'd1);
    chk("ill_pc1.illegal",    32'(illegal),    32'd1);
    chk("ill_pc1.illegal_pc", 32'(illegal_pc), 32'd1);
    fetch_decode(8'd0);
    chk("ill_sticky.illegal_pc", 32'(illegal_pc), 32'd1);

    // Full store: load_start drops a simultaneous word, then 256 words with gaps.
    start_load();
    load_start = 1'b1; load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    chk("full.start_drops_word", 32'(load_count), 32'd0);
    for (int i = 0; i < 256; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      push_word(32'h0140_0000 | 32'(i), 1'b0);
    end
    chk("full.count", 32'(load_count), 32'd256);
    chk("full.done",  32'(load_done),  32'd1);
    chk("full.ready", 32'(load_ready), 32'd0);
    push_word(32'h0FF0_0000, 1'b0);
    chk("full.word257_dropped", 32'(load_count), 32'd256);
    fetch_decode(8'd255);
    chk_dec("comp_pc255", 4'h1, 4'h4, 10'h0, 10'h0FF);
    fetch_decode(8'd17);
    chk_dec("comp_pc17", 4'h1, 4'h4, 10'h0, 10'h011);

    // Asynchronous reset mid-load.
    start_load();
    push_word(32'h0121_0040, 1'b0);
    push_word(32'h0121_0040, 1'b0);
    chk("midrst.count_before", 32'(load_count), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("midrst.count", 32'(load_count), 32'd0);
    chk("midrst.ready", 32'(load_ready), 32'd0);
    chk("midrst.done",  32'(load_done),  32'd0);
    chk("midrst.illegal", 32'(illegal),  32'd0);
    chk_dec("midrst", 4'h0, 4'h0, 10'h0, 10'h0);
    #2 reset = 1'b1;
    tick();
    chk("midrst.empty_no_ready", 32'(load_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
